// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: two requester ports (A = core load/store,
// B = loader/debug) plus the data-memory side. The slave modport is the
// arbiter's view; the master modport is the requesters and the memory.
interface dmem_arbiter_if;
    logic        a_req, a_we;
    logic [63:0] a_addr, a_wdata;
    logic        a_gnt, a_rvalid, a_err;
    logic [63:0] a_rdata;

    logic        b_req, b_we;
    logic [63:0] b_addr, b_wdata;
    logic        b_gnt, b_rvalid, b_err;
    logic [63:0] b_rdata;

    logic [63:0] mem_addr, mem_wdata;
    logic        mem_write, mem_read;
    logic [63:0] mem_rdata;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_err, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_err, b_rdata,
        output mem_addr, mem_wdata, mem_write, mem_read,
        input  mem_rdata
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_err, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_err, b_rdata,
        input  mem_addr, mem_wdata, mem_write, mem_read,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single 64-bit data memory.
// Each transaction walks IDLE -> ACCESS -> RESP, one cycle per busy state.
// Optional feature: define DMEM_ARB_BOUNDS_CHK_EN to suppress memory access
// for addresses whose 8-byte window runs past MEM_BYTES and flag x_err.
module dmem_arbiter #(
    parameter int MEM_BYTES = 64
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

`ifdef DMEM_ARB_BOUNDS_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state;
    logic              ptr;        // priority owner on a tie: 0 = A, 1 = B
    logic              owner;      // port being served
    logic              cmd_we;
    logic              cmd_oob;
    logic [1:0]        gnt, rvalid, err;
    logic [1:0][63:0]  rdata;
    logic [63:0]       mem_addr_q, mem_wdata_q;
    logic              mem_write_q, mem_read_q;

    // Index 0 is port A, index 1 is port B throughout.
    logic [1:0]        req, req_we;
    logic [1:0][63:0]  req_addr, req_wdata;
    logic              win, win_oob;

    assign req       = {bus.b_req, bus.a_req};
    assign req_we    = {bus.b_we, bus.a_we};
    assign req_addr  = {bus.b_addr, bus.a_addr};
    assign req_wdata = {bus.b_wdata, bus.a_wdata};

    // Lone requester wins; on a tie the pointer owner wins.
    always_comb begin
        win = (&req) ? ptr : req[1];
    end

    // 65-bit compare so addresses near 2^64 cannot wrap into range.
    assign win_oob = CHK_EN &&
        (({1'b0, req_addr[win]} + 65'd7) > 65'(MEM_BYTES - 1));

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= 1'b0;
            owner       <= 1'b0;
            cmd_we      <= 1'b0;
            cmd_oob     <= 1'b0;
            gnt         <= '0;
            rvalid      <= '0;
            err         <= '0;
            rdata       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner       <= win;
                        cmd_we      <= req_we[win];
                        cmd_oob     <= win_oob;
                        gnt[win]    <= 1'b1;
                        mem_addr_q  <= req_addr[win];
                        mem_wdata_q <= req_wdata[win];
                        mem_write_q <= req_we[win] && !win_oob;
                        mem_read_q  <= !req_we[win] && !win_oob;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    gnt         <= '0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    mem_write_q <= 1'b0;
                    mem_read_q  <= 1'b0;
                    if (!cmd_we)
                        rdata[owner] <= cmd_oob ? 64'd0 : bus.mem_rdata;
                    rvalid[owner] <= 1'b1;
                    err[owner]    <= cmd_oob;
                    state         <= RESP;
                end
                RESP: begin
                    rvalid <= '0;
                    err    <= '0;
                    ptr    <= ~owner;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.a_gnt     = gnt[0];
    assign bus.b_gnt     = gnt[1];
    assign bus.a_rvalid  = rvalid[0];
    assign bus.b_rvalid  = rvalid[1];
    assign bus.a_err     = err[0];
    assign bus.b_err     = err[1];
    assign bus.a_rdata   = rdata[0];
    assign bus.b_rdata   = rdata[1];
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_read  = mem_read_q;

endmodule
